// File: rtl/cbud_mon.sv
// Direction monitor for a 3-bit up/down counter: recovers DIR from successive
// samples of Q, counts the run length, flags reversals, wraps and illegal steps.
module cbud_mon (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic [2:0] Q,
    output logic       DIR,
    output logic       VLD,
    output logic       CHG,
    output logic       WRAP,
    output logic       ERR,
    output logic [3:0] RUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_UP,
        S_DOWN,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_HOLD,
        C_UP,
        C_DN,
        C_ILL
    } step_t;

    state_t     state_q, state_d;
    logic [2:0] prev_q,  prev_d;
    logic [3:0] run_q,   run_d;
    logic       dir_q,   dir_d;
    logic       vld_q,   vld_d;
    logic       chg_q,   chg_d;
    logic       wrap_q,  wrap_d;
    logic       err_q,   err_d;

    logic [2:0] delta;
    step_t      step;

    function automatic logic [3:0] run_inc(input logic [3:0] r);
        return (r == 4'hF) ? r : r + 4'd1;
    endfunction

    // Modulo-8 difference between consecutive samples decides the step kind.
    function automatic step_t classify(input logic [2:0] d);
        step_t s;
        case (d)
            3'd0:    s = C_HOLD;
            3'd1:    s = C_UP;
            3'd7:    s = C_DN;
            default: s = C_ILL;
        endcase
        return s;
    endfunction

    assign delta = Q - prev_q;
    assign step  = classify(delta);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        dir_d   = dir_q;
        chg_d   = 1'b0;
        wrap_d  = 1'b0;

        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    prev_d  = Q;
                    state_d = S_ARMED;
                end
                S_ARMED, S_UP, S_DOWN: begin
                    prev_d = Q;
                    wrap_d = ((step == C_UP) && (prev_q == 3'b111)) ||
                             ((step == C_DN) && (prev_q == 3'b000));
                    case (step)
                        C_UP: begin
                            dir_d = 1'b0;
                            if (state_q == S_UP) begin
                                run_d = run_inc(run_q);
                            end else begin
                                state_d = S_UP;
                                run_d   = 4'd1;
                                chg_d   = (state_q == S_DOWN);
                            end
                        end
                        C_DN: begin
                            dir_d = 1'b1;
                            if (state_q == S_DOWN) begin
                                run_d = run_inc(run_q);
                            end else begin
                                state_d = S_DOWN;
                                run_d   = 4'd1;
                                chg_d   = (state_q == S_UP);
                            end
                        end
                        C_ILL: begin
                            state_d = S_FAULT;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end

        // FAULT is terminal until CLR, so ERR derived from the state is sticky.
        vld_d = (state_d == S_UP) || (state_d == S_DOWN);
        err_d = (state_d == S_FAULT);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            prev_q  <= 3'b000;
            run_q   <= 4'h0;
            dir_q   <= 1'b0;
            vld_q   <= 1'b0;
            chg_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
            vld_q   <= vld_d;
            chg_q   <= chg_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign DIR  = dir_q;
    assign VLD  = vld_q;
    assign CHG  = chg_q;
    assign WRAP = wrap_q;
    assign ERR  = err_q;
    assign RUN  = run_q;

endmodule

// File: tb/tb_cbud_mon.sv
// Scoreboard bench for cbud_mon: a reference model predicts every cycle's
// outputs from the driven inputs; a separate monitor pops and compares.
module tb_cbud_mon;

    logic       CLK;
    logic       CLR;
    logic       EN;
    logic [2:0] Q;
    logic       DIR;
    logic       VLD;
    logic       CHG;
    logic       WRAP;
    logic       ERR;
    logic [3:0] RUN;

    cbud_mon dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .EN   (EN),
        .Q    (Q),
        .DIR  (DIR),
        .VLD  (VLD),
        .CHG  (CHG),
        .WRAP (WRAP),
        .ERR  (ERR),
        .RUN  (RUN)
    );

    typedef struct packed {
        logic       vld;
        logic       dir;
        logic       chg;
        logic       wrap;
        logic       err;
        logic [3:0] run;
    } exp_t;

    exp_t sb[$];

    int errors   = 0;
    int checks   = 0;
    int wrap_cnt = 0;

    // Reference model state: mode 0=idle 1=armed 2=up 3=down 4=fault
    int m_mode = 0;
    int m_prev = 0;
    int m_run  = 0;
    int m_dir  = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit clr, input bit en, input int q);
        exp_t e;
        int   d;
        int   want;
        e.chg  = 1'b0;
        e.wrap = 1'b0;
        if (clr) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_dir = 0;
        end else if (en) begin
            if (m_mode == 0) begin
                m_prev = q;
                m_mode = 1;
            end else if (m_mode != 4) begin
                d = (q - m_prev + 8) % 8;
                if (d == 1 || d == 7) begin
                    want   = (d == 1) ? 2 : 3;
                    e.wrap = (d == 1 && m_prev == 7) || (d == 7 && m_prev == 0);
                    m_dir  = (d == 7) ? 1 : 0;
                    if (m_mode == want) begin
                        m_run = (m_run < 15) ? m_run + 1 : 15;
                    end else begin
                        e.chg  = (m_mode != 1);
                        m_run  = 1;
                        m_mode = want;
                    end
                end else if (d != 0) begin
                    m_mode = 4;
                end
                m_prev = q;
            end
        end
        e.vld = (m_mode == 2 || m_mode == 3);
        e.err = (m_mode == 4);
        e.dir = m_dir[0];
        e.run = m_run[3:0];
        return e;
    endfunction

    task automatic step(input bit clr, input bit en, input int q);
        @(negedge CLK);
        CLR = clr;
        EN  = en;
        Q   = q[2:0];
        sb.push_back(model(clr, en, q));
    endtask

    // Monitor: one prediction per clocked sample, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("VLD",  VLD,  e.vld);
                chk("DIR",  DIR,  e.dir);
                chk("CHG",  CHG,  e.chg);
                chk("WRAP", WRAP, e.wrap);
                chk("ERR",  ERR,  e.err);
                chk("RUN",  RUN,  e.run);
                if (WRAP === 1'b1) wrap_cnt++;
            end
        end
    end

    task automatic expect_now(input string tag, input int vld, input int dir,
                              input int err, input int run);
        @(posedge CLK);
        #2;
        chk({tag, ".VLD"}, VLD, vld);
        chk({tag, ".DIR"}, DIR, dir);
        chk({tag, ".ERR"}, ERR, err);
        chk({tag, ".RUN"}, RUN, run);
    endtask

    initial begin
        int lq;
        int r;
        bit en;
        CLR = 1'b1;
        EN  = 1'b0;
        Q   = 3'd0;

        // Counting up through the 7->0 wrap
        step(1, 0, 0);
        wrap_cnt = 0;
        for (int i = 0; i < 10; i++) step(0, 1, i % 8);
        expect_now("up9", 1, 0, 0, 9);
        chk("up9.wraps", wrap_cnt, 1);

        // Counting down through the 0->7 wrap
        step(1, 0, 0);
        wrap_cnt = 0;
        step(0, 1, 3); step(0, 1, 2); step(0, 1, 1);
        step(0, 1, 0); step(0, 1, 7); step(0, 1, 6);
        expect_now("dn5", 1, 1, 0, 5);
        chk("dn5.wraps", wrap_cnt, 1);

        // Reversal
        step(1, 0, 0);
        step(0, 1, 4); step(0, 1, 5); step(0, 1, 6);
        expect_now("rev.pre", 1, 0, 0, 2);
        step(0, 1, 5);
        expect_now("rev", 1, 1, 0, 1);
        chk("rev.CHG", CHG, 1);
        step(0, 0, 5);
        expect_now("rev.post", 1, 1, 0, 1);
        chk("rev.post.CHG", CHG, 0);

        // Holds keep RUN, EN=0 freezes everything
        step(1, 0, 0);
        step(0, 1, 2); step(0, 1, 3);
        expect_now("hold.a", 1, 0, 0, 1);
        step(0, 1, 3); step(0, 1, 3);
        expect_now("hold.b", 1, 0, 0, 1);
        step(0, 1, 4);
        expect_now("hold.c", 1, 0, 0, 2);
        step(0, 0, 0); step(0, 0, 7); step(0, 0, 1);
        expect_now("en0", 1, 0, 0, 2);

        // Illegal step, sticky fault, then clear and re-arm
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 2); step(0, 1, 5);
        expect_now("ill", 0, 0, 1, 1);
        step(0, 1, 6); step(0, 1, 7); step(0, 1, 0);
        expect_now("ill.stuck", 0, 0, 1, 1);
        step(1, 1, 1);
        expect_now("clr", 0, 0, 0, 0);
        chk("clr.CHG", CHG, 0);
        chk("clr.WRAP", WRAP, 0);
        step(0, 1, 3);
        expect_now("rearm", 0, 0, 0, 0);
        step(0, 1, 4);
        expect_now("rearm.up", 1, 0, 0, 1);

        // Saturation of RUN
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 1; i <= 20; i++) step(0, 1, i % 8);
        expect_now("sat", 1, 0, 0, 15);

        // Random mostly-legal walk with occasional clears and jumps
        lq = 0;
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 9);
            en = ($urandom_range(0, 3) != 0);
            if (r <= 3)      lq = (lq + 1) % 8;
            else if (r <= 6) lq = (lq + 7) % 8;
            else if (r == 9) lq = $urandom_range(0, 7);
            step(($urandom_range(0, 59) == 0), en, lq);
        end

        @(negedge CLK);
        EN  = 1'b0;
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        chk("sb.drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
